// File: rtl/systolic_matmul_nxn.sv
// N x N output-stationary systolic matrix multiplier, C = A x B or C += A x B.
// Operand skew is generated internally; valid/ready handshake on both sides.
module systolic_matmul_nxn #(
   parameter int N      = 4,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 2*DATA_W+$clog2(N),
   parameter bit SIGNED = 1'b0
) (
   input  logic                                   i_clk,
   input  logic                                   i_arst_n,
   input  logic                                   i_valid,
   output logic                                   o_ready,
   input  logic                                   i_acc,
   input  logic [N-1:0][N-1:0][DATA_W-1:0]        i_a,
   input  logic [N-1:0][N-1:0][DATA_W-1:0]        i_b,
   output logic                                   o_valid,
   input  logic                                   i_ready,
   output logic [N-1:0][N-1:0][ACC_W-1:0]         o_c
);

   localparam int            CW   = $clog2(3*N);
   localparam logic [CW-1:0] LAST = CW'(3*N-3);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                               state;
   logic [CW-1:0]                        cnt;
   logic [N-1:0][N-1:0][DATA_W-1:0]      a_lat;
   logic [N-1:0][N-1:0][DATA_W-1:0]      b_lat;
   logic [N-1:0][N-1:0][DATA_W-1:0]      a_pipe;
   logic [N-1:0][N-1:0][DATA_W-1:0]      b_pipe;
   logic [N-1:0][N-1:0][DATA_W-1:0]      a_in;
   logic [N-1:0][N-1:0][DATA_W-1:0]      b_in;
   logic [N-1:0][N-1:0][ACC_W-1:0]       prod;
   logic [N-1:0][N-1:0][ACC_W-1:0]       acc;
   logic [N-1:0][DATA_W-1:0]             a_inj;
   logic [N-1:0][DATA_W-1:0]             b_inj;
   logic                                 accept;
   logic                                 run;

   assign accept = i_valid & o_ready;
   assign run    = (state == RUN);
   assign o_c    = acc;

   // Product widened to the accumulator, zero- or sign-extended.
   function automatic logic [ACC_W-1:0] mul_ext(
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b
   );
      logic signed [2*DATA_W-1:0] ps;
      logic        [2*DATA_W-1:0] pu;
      ps = $signed({{DATA_W{a[DATA_W-1]}}, a}) *
           $signed({{DATA_W{b[DATA_W-1]}}, b});
      pu = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
      if (SIGNED) return ACC_W'(ps);
      else        return ACC_W'(pu);
   endfunction

   // Control FSM: handshake, run counter and operand latches.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state   <= IDLE;
         o_ready <= 1'b1;
         o_valid <= 1'b0;
         cnt     <= '0;
         a_lat   <= '0;
         b_lat   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  a_lat   <= i_a;
                  b_lat   <= i_b;
                  cnt     <= '0;
                  o_ready <= 1'b0;
                  state   <= RUN;
               end
            end
            RUN: begin
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  o_valid <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               if (i_ready) begin
                  o_valid <= 1'b0;
                  o_ready <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Skewed edge injectors: row i gets A[i][cnt-i], column j gets B[cnt-j][j].
   always_comb begin
      a_inj = '0;
      b_inj = '0;
      for (int i = 0; i < N; i++) begin
         for (int k = 0; k < N; k++) begin
            if (cnt == CW'(i+k)) begin
               a_inj[i] = a_lat[i][k];
               b_inj[i] = b_lat[k][i];
            end
         end
      end
   end

   // PE inputs come from the injectors at the edges, else from the neighbour.
   always_comb begin
      a_in = '0;
      b_in = '0;
      prod = '0;
      for (int i = 0; i < N; i++) begin
         a_in[i][0] = a_inj[i];
         b_in[0][i] = b_inj[i];
         for (int j = 1; j < N; j++) begin
            a_in[i][j] = a_pipe[i][j-1];
            b_in[j][i] = b_pipe[j-1][i];
         end
      end
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            prod[i][j] = mul_ext(a_in[i][j], b_in[i][j]);
         end
      end
   end

   // PE array: multiply-accumulate and forward operands while running.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         a_pipe <= '0;
         b_pipe <= '0;
         acc    <= '0;
      end else if (accept) begin
         a_pipe <= '0;
         b_pipe <= '0;
         if (!i_acc) acc <= '0;
      end else if (run) begin
         a_pipe <= a_in;
         b_pipe <= b_in;
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               acc[i][j] <= acc[i][j] + prod[i][j];
            end
         end
      end
   end

endmodule

// File: tb/tb_systolic_matmul_nxn.sv
// Directed bench for systolic_matmul_nxn: four instances
// (N=4 unsigned, N=4/2/8 signed) sharing clock, reset and handshake.
module tb_systolic_matmul_nxn;

   logic clk = 1'b0;
   logic rst_n;
   logic i_valid;
   logic i_ready;
   logic i_acc;

   logic [3:0][3:0][7:0]  u4_a, u4_b;
   logic [3:0][3:0][17:0] u4_c;
   logic                  u4_rdy, u4_ov;
   logic [3:0][3:0][7:0]  s4_a, s4_b;
   logic [3:0][3:0][17:0] s4_c;
   logic                  s4_rdy, s4_ov;
   logic [1:0][1:0][7:0]  s2_a, s2_b;
   logic [1:0][1:0][16:0] s2_c;
   logic                  s2_rdy, s2_ov;
   logic [7:0][7:0][7:0]  s8_a, s8_b;
   logic [7:0][7:0][18:0] s8_c;
   logic                  s8_rdy, s8_ov;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   systolic_matmul_nxn #(.N(4), .DATA_W(8), .SIGNED(1'b0)) u4 (
      .i_clk(clk), .i_arst_n(rst_n), .i_valid(i_valid), .o_ready(u4_rdy),
      .i_acc(i_acc), .i_a(u4_a), .i_b(u4_b), .o_valid(u4_ov),
      .i_ready(i_ready), .o_c(u4_c));

   systolic_matmul_nxn #(.N(4), .DATA_W(8), .SIGNED(1'b1)) s4 (
      .i_clk(clk), .i_arst_n(rst_n), .i_valid(i_valid), .o_ready(s4_rdy),
      .i_acc(i_acc), .i_a(s4_a), .i_b(s4_b), .o_valid(s4_ov),
      .i_ready(i_ready), .o_c(s4_c));

   systolic_matmul_nxn #(.N(2), .DATA_W(8), .SIGNED(1'b1)) s2 (
      .i_clk(clk), .i_arst_n(rst_n), .i_valid(i_valid), .o_ready(s2_rdy),
      .i_acc(i_acc), .i_a(s2_a), .i_b(s2_b), .o_valid(s2_ov),
      .i_ready(i_ready), .o_c(s2_c));

   systolic_matmul_nxn #(.N(8), .DATA_W(8), .SIGNED(1'b1)) s8 (
      .i_clk(clk), .i_arst_n(rst_n), .i_valid(i_valid), .o_ready(s8_rdy),
      .i_acc(i_acc), .i_a(s8_a), .i_b(s8_b), .o_valid(s8_ov),
      .i_ready(i_ready), .o_c(s8_c));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Operand element: 0 identity, 1 n*r+c, 2 constant v.
   function automatic logic [7:0] elem(input int n, input int m,
                                       input int v, input int r,
                                       input int c);
      if (m == 0) return (r == c) ? 8'd1 : 8'd0;
      if (m == 1) return 8'(n*r+c);
      return 8'(v);
   endfunction

   // Expected C element: 0 constant v, 1 n*r+c, 2 diagonal v.
   function automatic logic [63:0] expc(input int n, input int m,
                                        input logic [63:0] v,
                                        input int r, input int c);
      if (m == 0) return v;
      if (m == 1) return 64'(n*r+c);
      return (r == c) ? v : 64'd0;
   endfunction

   task automatic load(input int inst, input int am, input int av,
                       input int bm, input int bv);
      case (inst)
         0: for (int r = 0; r < 4; r++)
               for (int c = 0; c < 4; c++) begin
                  u4_a[r][c] = elem(4, am, av, r, c);
                  u4_b[r][c] = elem(4, bm, bv, r, c);
               end
         1: for (int r = 0; r < 4; r++)
               for (int c = 0; c < 4; c++) begin
                  s4_a[r][c] = elem(4, am, av, r, c);
                  s4_b[r][c] = elem(4, bm, bv, r, c);
               end
         2: for (int r = 0; r < 2; r++)
               for (int c = 0; c < 2; c++) begin
                  s2_a[r][c] = elem(2, am, av, r, c);
                  s2_b[r][c] = elem(2, bm, bv, r, c);
               end
         default: for (int r = 0; r < 8; r++)
               for (int c = 0; c < 8; c++) begin
                  s8_a[r][c] = elem(8, am, av, r, c);
                  s8_b[r][c] = elem(8, bm, bv, r, c);
               end
      endcase
   endtask

   task automatic chk_mat(input string tag, input int inst, input int m,
                          input logic [63:0] v);
      case (inst)
         0: for (int r = 0; r < 4; r++)
               for (int c = 0; c < 4; c++)
                  chk($sformatf("%s_u4[%0d][%0d]", tag, r, c),
                      64'(u4_c[r][c]), expc(4, m, v, r, c));
         1: for (int r = 0; r < 4; r++)
               for (int c = 0; c < 4; c++)
                  chk($sformatf("%s_s4[%0d][%0d]", tag, r, c),
                      64'(s4_c[r][c]), expc(4, m, v, r, c));
         2: for (int r = 0; r < 2; r++)
               for (int c = 0; c < 2; c++)
                  chk($sformatf("%s_s2[%0d][%0d]", tag, r, c),
                      64'(s2_c[r][c]), expc(2, m, v, r, c));
         default: for (int r = 0; r < 8; r++)
               for (int c = 0; c < 8; c++)
                  chk($sformatf("%s_s8[%0d][%0d]", tag, r, c),
                      64'(s8_c[r][c]), expc(8, m, v, r, c));
      endcase
   endtask

   task automatic go(input logic acc);
      i_acc   = acc;
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      i_acc   = 1'b0;
   endtask

   // Counts cycles from the accepting edge to each o_valid rise.
   task automatic wait_done(input string tag);
      int lat[4];
      int hi;
      lat = '{0, 0, 0, 0};
      hi  = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         tick();
         if (u4_ov) hi++;
         if (u4_ov && lat[0] == 0) lat[0] = cyc;
         if (s4_ov && lat[1] == 0) lat[1] = cyc;
         if (s2_ov && lat[2] == 0) lat[2] = cyc;
         if (s8_ov && lat[3] == 0) lat[3] = cyc;
         if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0 && lat[3] != 0 &&
             (!i_ready || !(u4_ov | s4_ov | s2_ov | s8_ov)))
            break;
      end
      chk({tag, "_lat_u4"}, 64'(lat[0]), 64'd10);
      chk({tag, "_lat_s4"}, 64'(lat[1]), 64'd10);
      chk({tag, "_lat_s2"}, 64'(lat[2]), 64'd4);
      chk({tag, "_lat_s8"}, 64'(lat[3]), 64'd22);
      if (i_ready) chk({tag, "_done_len"}, 64'(hi), 64'd1);
   endtask

   initial begin
      rst_n   = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b1;
      i_acc   = 1'b0;
      for (int i = 0; i < 4; i++) load(i, 0, 0, 0, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      chk("rst_rdy", 64'(u4_rdy), 64'd1);
      chk("rst_ov", 64'(u4_ov), 64'd0);
      chk("rst_c_u4", 64'(u4_c == '0), 64'd1);
      chk("rst_c_s8", 64'(s8_c == '0), 64'd1);

      // Identity x pattern, and -128 x -128 on the N=4 signed instance.
      load(0, 0, 0, 1, 0);
      load(1, 2, 128, 2, 128);
      load(2, 0, 0, 1, 0);
      load(3, 0, 0, 1, 0);
      go(1'b0);
      wait_done("r1");
      chk_mat("r1", 0, 1, 0);
      chk_mat("r1", 1, 0, 64'd65536);
      chk_mat("r1", 2, 1, 0);
      chk_mat("r1", 3, 1, 0);
      load(0, 2, 7, 2, 9);
      repeat (3) tick();
      chk("r1_idle_rdy", 64'(u4_rdy), 64'd1);
      chk_mat("r1_idle", 0, 1, 0);

      // Full-scale operands.
      load(0, 2, 255, 2, 255);
      load(1, 2, 128, 2, 127);
      load(2, 2, 128, 2, 128);
      load(3, 2, 128, 2, 128);
      go(1'b0);
      wait_done("r2");
      chk_mat("r2", 0, 0, 64'd260100);
      chk_mat("r2", 1, 0, 64'h30200);
      chk_mat("r2", 2, 0, 64'd32768);
      chk_mat("r2", 3, 0, 64'd131072);

      // Accumulate onto the previous results.
      load(0, 2, 255, 2, 0);
      load(1, 2, 128, 2, 128);
      load(2, 2, 128, 2, 127);
      load(3, 2, 128, 2, 127);
      go(1'b1);
      wait_done("r3");
      chk_mat("r3", 0, 0, 64'd260100);
      chk_mat("r3", 1, 0, 64'd512);
      chk_mat("r3", 2, 0, 64'd256);
      chk_mat("r3", 3, 0, 64'd1024);

      // Identity x identity with acc 0, 1, 0.
      for (int i = 0; i < 4; i++) load(i, 0, 0, 0, 0);
      go(1'b0);
      wait_done("r4");
      for (int i = 0; i < 4; i++) chk_mat("r4", i, 2, 64'd1);
      go(1'b1);
      wait_done("r5");
      for (int i = 0; i < 4; i++) chk_mat("r5", i, 2, 64'd2);
      go(1'b0);
      wait_done("r6");
      for (int i = 0; i < 4; i++) chk_mat("r6", i, 2, 64'd1);

      // Backpressure in DONE with stray i_valid pulses.
      for (int i = 0; i < 4; i++) load(i, 0, 0, 1, 0);
      i_ready = 1'b0;
      go(1'b0);
      wait_done("bp");
      for (int k = 0; k < 20; k++) begin
         i_valid = (k % 5 == 2);
         tick();
         chk($sformatf("bp_ov_%0d", k), 64'(u4_ov), 64'd1);
         chk($sformatf("bp_rdy_%0d", k), 64'(u4_rdy), 64'd0);
      end
      i_valid = 1'b0;
      chk_mat("bp_hold", 0, 1, 0);
      i_ready = 1'b1;
      tick();
      chk("bp_hs_ov", 64'(u4_ov), 64'd0);
      chk("bp_hs_rdy", 64'(u4_rdy), 64'd1);
      chk("bp_hs_rdy_s8", 64'(s8_rdy), 64'd1);
      tick();
      chk("bp_idle_rdy", 64'(u4_rdy), 64'd1);
      chk_mat("bp_after", 0, 1, 0);
      chk_mat("bp_after", 3, 1, 0);

      // Reset at cnt=5 discards the partial result.
      for (int i = 0; i < 4; i++) load(i, 0, 0, 0, 0);
      go(1'b0);
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      chk("mr_ov", 64'(u4_ov), 64'd0);
      chk("mr_rdy", 64'(u4_rdy), 64'd1);
      chk("mr_c_u4", 64'(u4_c == '0), 64'd1);
      chk("mr_rdy_s8", 64'(s8_rdy), 64'd1);
      chk("mr_c_s8", 64'(s8_c == '0), 64'd1);
      tick();
      rst_n = 1'b1;
      tick();
      go(1'b0);
      wait_done("r9");
      for (int i = 0; i < 4; i++) chk_mat("r9", i, 2, 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
